sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Digital successive-approximation controller for the on-chip ADC. It sits directly upstream of the analog capacitive DAC / comparator macro on the `ua` pins: it drives the track/hold switch and the DAC trial code, and reads back the asynchronous comparator decision. It produces a RES_BITS-wide conversion result with a one-cycle valid strobe for the output logic on `uo_out`. Single-shot and free-running conversion modes are supported.

## Interface
- RES_BITS, 8, conversion resolution in bits.
- SAMPLE_CYCLES, 4, number of cycles `sample_en` is held high per conversion (≥1).
- SETTLE_CYCLES, 4, cycles allowed per bit for DAC settling plus comparator synchronisation (≥3).

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  block enable; when low, forces IDLE on the next edge.
- start  in  1  requests a conversion; sampled only in IDLE.
- cont  in  1  free-running mode; sampled in DONE.
- comp_in  in  1  asynchronous comparator output; 1 means Vin ≥ Vdac.
- sample_en  out  1  track/hold switch; high while tracking.
- dac_code  out  RES_BITS  DAC trial code.
- result  out  RES_BITS  last completed conversion, held until the next DONE.
- result_valid  out  1  one-cycle strobe marking a new result.
- busy  out  1  high in every state except IDLE.

## Operation
- comp_in passes through a 2-flop synchroniser whose flops reset to 0. Only the synchronised value `comp_s` is used.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: `start`=1 and `ena`=1 → SAMPLE.
- SAMPLE: `sample_en`=1 and `dac_code`=0. After SAMPLE_CYCLES cycles → CONVERT, with bit index i=RES_BITS-1 and trial register T=0.
- CONVERT, per bit i:
  - `dac_code` = T | (1<<i) for SETTLE_CYCLES cycles.
  - On the last of those cycles, bit i of T is set to `comp_s`.
  - If i=0 → DONE; otherwise i decrements.
- DONE (one cycle):
  - `result` ← final T; `result_valid`=1; `dac_code`=0.
  - Next state is SAMPLE if `cont`=1 and `ena`=1, else IDLE.
- `start` asserted while `busy`=1 is ignored. It is not queued.
- `ena`=0 in any state: next state is IDLE and `dac_code`=0. An in-flight conversion is discarded, with no `result_valid` and `result` unchanged.
- Arithmetic: T, `dac_code` and `result` are unsigned RES_BITS wide. A comparator held high yields all-ones; held low yields 0.

## Timing
- Reset values: `sample_en`=0, `dac_code`=0, `result`=0, `result_valid`=0, `busy`=0, state=IDLE, synchroniser flops=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Define edge 0 as the edge that samples `start`=1 in IDLE.
  - `busy` and `sample_en` are high from edge 0 through edge SAMPLE_CYCLES.
  - The MSB trial code appears after edge SAMPLE_CYCLES.
  - Bit k (MSB = k=0) is decided at edge SAMPLE_CYCLES+(k+1)·SETTLE_CYCLES.
  - `result_valid` is high for the single cycle following edge L = SAMPLE_CYCLES + RES_BITS·SETTLE_CYCLES + 1. With defaults, L = 37.
- `busy` drops after edge L+1 unless `cont` continues.
- Free-running period is L cycles. SAMPLE directly follows DONE with no IDLE gap.
- Comparator latency: `comp_in` must be stable by SETTLE_CYCLES−2 cycles after each `dac_code` change.
- Reset asserted mid-conversion: all outputs take their reset values immediately (asynchronous). After release, the block waits in IDLE for a new `start`.
- `start` and `ena` falling in the same cycle in IDLE: `ena` wins and the block stays IDLE.

## Test plan
- `comp_in` held 1, single `start` pulse → `result`=0xFF with `result_valid` after edge 37, then `busy` low; `sample_en` high for exactly 4 cycles.
- `comp_in` held 0 → `result`=0x00 at edge 37; `dac_code` steps 0x80, 0x40, 0x20 … each held 4 cycles.
- Bench model `comp_in` = (0x5A ≥ `dac_code`) → `dac_code` sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B; `result`=0x5A.
- `cont`=1 with Vin model 0x33 → `result_valid` pulses exactly every 37 cycles and `busy` never drops; extra `start` pulses mid-conversion change nothing.
- `rst_n` low at edge 20 of a conversion → all outputs 0 immediately; after release, a fresh `start` gives a correct 0x5A.
- `ena` low at edge 15 → IDLE at the next edge, no `result_valid`, `result` keeps its previous value.

Source files
------------

// File: rtl/sar_adc_ctrl_if.sv
// Handshake/data bundle between the SAR controller, the analog macro pins and
// the result logic.
interface sar_adc_ctrl_if #(parameter int RES_BITS = 8);
  logic                ena;
  logic                start;
  logic                cont;
  logic                comp_in;
  logic                sample_en;
  logic [RES_BITS-1:0] dac_code;
  logic [RES_BITS-1:0] result;
  logic                result_valid;
  logic                busy;

  modport master (output ena, start, cont, comp_in,
                  input  sample_en, dac_code, result, result_valid, busy);
  modport slave  (input  ena, start, cont, comp_in,
                  output sample_en, dac_code, result, result_valid, busy);
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives track/hold and the DAC trial code,
// resolves one bit per SETTLE_CYCLES window from the synchronised comparator.
module sar_adc_ctrl #(
  parameter int RES_BITS      = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sar_adc_ctrl_if.slave  bus
);
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t              r_state, w_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [RES_BITS-1:0] r_t, w_t_nxt, w_dac_nxt;
  logic                r_sync1, r_comp_s;
  logic                r_sample_en, r_busy, r_result_valid;
  logic [RES_BITS-1:0] r_dac_code, r_result;
  logic                w_done_ok;

  assign w_done_ok = (r_state == DONE) && bus.ena;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_comp_s <= 1'b0;
    end else begin
      r_sync1  <= bus.comp_in;
      r_comp_s <= r_sync1;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    w_t_nxt   = r_t;
    case (r_state)
      IDLE: if (bus.start) begin
        w_nxt     = SAMPLE;
        w_cnt_nxt = '0;
      end
      SAMPLE: if (r_cnt == CW'(SAMPLE_CYCLES - 1)) begin
        w_nxt     = CONVERT;
        w_cnt_nxt = '0;
        w_idx_nxt = IW'(RES_BITS - 1);
        w_t_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      CONVERT: if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
        w_cnt_nxt        = '0;
        w_t_nxt[r_idx]   = r_comp_s;
        if (r_idx == '0) w_nxt = DONE;
        else             w_idx_nxt = r_idx - 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      DONE: begin
        w_cnt_nxt = '0;
        w_nxt     = bus.cont ? SAMPLE : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (!bus.ena) w_nxt = IDLE;
    w_dac_nxt = (w_nxt == CONVERT) ? (w_t_nxt | (RES_BITS'(1) << w_idx_nxt)) : '0;
  end

  // busy stays up through the result_valid cycle so it covers the whole conversion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_t            <= '0;
      r_sample_en    <= 1'b0;
      r_dac_code     <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_nxt;
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_t            <= w_t_nxt;
      r_sample_en    <= (w_nxt == SAMPLE);
      r_dac_code     <= w_dac_nxt;
      r_result_valid <= w_done_ok;
      r_busy         <= (w_nxt != IDLE) || w_done_ok;
      if (w_done_ok) r_result <= r_t;
    end
  end

  assign bus.sample_en    = r_sample_en;
  assign bus.dac_code     = r_dac_code;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed + randomized bench for sar_adc_ctrl against a binary-search reference.
module tb_sar_adc_ctrl;
  localparam int RB = 8, SC = 4, ST = 4;
  localparam int L  = SC + RB * ST + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  int   n_vec = 0, n_mis = 0;
  int   cmp_mode = 0;          // 0: comparator low, 1: high, 2: Vin model
  logic [RB-1:0] vin = '0;

  sar_adc_ctrl_if #(.RES_BITS(RB)) bus ();
  sar_adc_ctrl #(.RES_BITS(RB), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.comp_in = (cmp_mode == 2) ? (vin >= bus.dac_code) : cmp_mode[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cmp(input logic [RB-1:0] code);
    if (cmp_mode == 2) return vin >= code;
    return cmp_mode[0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full single-shot conversion, checked every cycle from edge 0 to edge L+1.
  task automatic run_conv(input int mode, input logic [RB-1:0] v);
    logic [RB-1:0] trial [RB];
    logic [RB-1:0] t;
    logic [RB-1:0] dac_e;
    cmp_mode = mode; vin = v;
    t = '0;
    for (int k = 0; k < RB; k++) begin
      trial[k] = t | (8'h80 >> k);
      if (cmp(trial[k])) t = trial[k];
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c <= L + 1; c++) begin
      if (c > 0) tick();
      dac_e = (c >= SC && c < SC + RB * ST) ? trial[(c - SC) / ST] : '0;
      chk("conv_cycle", {21'd0, bus.sample_en, bus.busy, bus.result_valid, bus.dac_code},
          {21'd0, 1'(c < SC), 1'(c <= L), 1'(c == L), dac_e});
      if (c == L) chk("conv_result", 32'(bus.result), 32'(t));
    end
  endtask

  initial begin
    bus.ena = 1'b1; bus.start = 1'b0; bus.cont = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_en", 32'(bus.sample_en), 0);
    chk("rst_dac", 32'(bus.dac_code), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_conv(1, '0);
    run_conv(0, '0);
    run_conv(2, 8'h5A);
    for (int r = 0; r < 4; r++) run_conv(2, RB'($urandom_range(0, 255)));
    run_conv(2, 8'h5A);

    // ena drop mid-conversion: discarded, result retained
    cmp_mode = 2; vin = 8'hC3;
    bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) tick();
    bus.ena = 1'b0;
    tick();
    chk("ena_off_state", {29'd0, bus.sample_en, bus.busy, |bus.dac_code}, 0);
    bus.ena = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("ena_off_hold", {23'd0, bus.result_valid, bus.result}, {23'd0, 1'b0, 8'h5A});
    end

    // start with ena low in IDLE stays IDLE
    bus.start = 1'b1; bus.ena = 1'b0;
    tick();
    bus.start = 1'b0; bus.ena = 1'b1;
    tick();
    chk("start_ena_low", {31'd0, bus.busy}, 0);

    // free-running at Vin 0x33, with ignored start pulses
    cmp_mode = 2; vin = 8'h33; bus.cont = 1'b1;
    bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 1; c <= 3 * L; c++) begin
      tick();
      if (c % L == 10) bus.start = 1'b1;
      else             bus.start = 1'b0;
      chk("free_run", {30'd0, bus.busy, bus.result_valid}, {30'd0, 1'b1, 1'(c % L == 0)});
      if (c % L == 0) chk("free_result", 32'(bus.result), 32'h33);
    end
    bus.start = 1'b0; bus.cont = 1'b0;
    begin
      int n = 0;
      while (bus.busy && n < 100) begin tick(); n++; end
      chk("free_stop_timeout", 32'(n < 100), 1);
    end

    // async reset mid-conversion
    cmp_mode = 2; vin = 8'hA5;
    bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {20'd0, bus.sample_en, bus.busy, bus.result_valid, bus.dac_code, |bus.result},
        0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("arst_idle", {31'd0, bus.busy}, 0);
    run_conv(2, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
